// File: rtl/prom_fuse_writer.sv
// Bipolar PROM word programmer: pre-read, then pulse/verify/retry each fuse that must go 0->1.
// Define PROM_FUSE_WRITER_BLANK_CHECK_EN to reject words whose pre-read has 1s the pattern lacks.
module prom_fuse_writer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDRESS_WIDTH   = 9,
    parameter int unsigned SETUP_CYCLES    = 50,
    parameter int unsigned PULSE_CYCLES    = 500,
    parameter int unsigned RECOVERY_CYCLES = 50,
    parameter int unsigned READ_CYCLES     = 10,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    chip_data_in,
    output logic [ADDRESS_WIDTH-1:0] chip_address_port,
    output logic [DATA_WIDTH-1:0]    chip_data_out,
    output logic                     chip_data_oe,
    output logic                     chip_select_n,
    output logic                     program_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    result_data
);

    localparam int unsigned MAX_SP    = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_RR    = (RECOVERY_CYCLES > READ_CYCLES) ? RECOVERY_CYCLES
                                                                        : READ_CYCLES;
    localparam int unsigned MAX_PHASE = (MAX_SP > MAX_RR) ? MAX_SP : MAX_RR;
    localparam int unsigned CNT_W     = $clog2(MAX_PHASE) + 1;
    localparam int unsigned BIT_W     = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [CNT_W-1:0]   READ_LOAD    = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RECOVER_LOAD = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT     = BIT_W'(DATA_WIDTH - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StScan,
        StSetup,
        StPulse,
        StRecover,
        StVerify,
        StFinish
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_W-1:0]         bit_index_q, bit_index_d;
    logic [RETRY_W-1:0]       retry_q, retry_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic                     fail_q, fail_d;

    logic [DATA_WIDTH-1:0] bit_mask;
    logic                  want_bit;
    logic                  have_bit;
    logic                  read_bit;
    logic                  cnt_zero;
    logic                  last_bit;
    logic                  blank_violation;

    assign bit_mask = DATA_WIDTH'(1) << bit_index_q;
    assign want_bit = |(wdata_q & bit_mask);
    assign have_bit = |(result_q & bit_mask);
    // Verify decides on the live read-back, the same value captured into result_data.
    assign read_bit = |(chip_data_in & bit_mask);
    assign cnt_zero = (cnt_q == '0);
    assign last_bit = (bit_index_q == LAST_BIT);

`ifdef PROM_FUSE_WRITER_BLANK_CHECK_EN
    assign blank_violation = |(chip_data_in & ~wdata_q);
`else
    assign blank_violation = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_index_q <= '0;
            retry_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_index_q <= bit_index_d;
            retry_q     <= retry_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_index_d = bit_index_q;
        retry_d     = retry_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        fail_d      = fail_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = write_address;
                    wdata_d     = write_data;
                    bit_index_d = '0;
                    retry_d     = '0;
                    fail_d      = 1'b0;
                    cnt_d       = READ_LOAD;
                    state_d     = StRead;
                end
            end
            StRead: begin
                if (cnt_zero) begin
                    result_d = chip_data_in;
                    if (blank_violation) begin
                        fail_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        state_d = StScan;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StScan: begin
                if (want_bit && !have_bit) begin
                    cnt_d   = SETUP_LOAD;
                    state_d = StSetup;
                end else if (last_bit) begin
                    state_d = StFinish;
                end else begin
                    bit_index_d = bit_index_q + 1'b1;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = PULSE_LOAD;
                    state_d = StPulse;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPulse: begin
                if (cnt_zero) begin
                    cnt_d   = RECOVER_LOAD;
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRecover: begin
                if (cnt_zero) begin
                    cnt_d   = READ_LOAD;
                    state_d = StVerify;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StVerify: begin
                if (cnt_zero) begin
                    result_d = chip_data_in;
                    if (read_bit) begin
                        retry_d = '0;
                        if (last_bit) begin
                            state_d = StFinish;
                        end else begin
                            bit_index_d = bit_index_q + 1'b1;
                            state_d     = StScan;
                        end
                    end else if (retry_q < RETRY_LIMIT) begin
                        cnt_d   = SETUP_LOAD;
                        state_d = StSetup;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = StFinish;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFinish: begin
                cnt_d       = '0;
                bit_index_d = '0;
                retry_d     = '0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset removes the pulse at once.
    always_comb begin
        chip_select_n  = 1'b1;
        chip_data_oe   = 1'b0;
        chip_data_out  = '0;
        program_enable = 1'b0;
        busy           = (state_q != StIdle);
        done           = (state_q == StFinish);
        error          = (state_q == StFinish) && fail_q;
        result_data    = result_q;

        case (state_q)
            StRead, StVerify: begin
                chip_select_n = 1'b0;
            end
            StSetup: begin
                chip_data_oe  = 1'b1;
                chip_data_out = bit_mask;
            end
            StPulse: begin
                chip_data_oe   = 1'b1;
                chip_data_out  = bit_mask;
                program_enable = 1'b1;
            end
            default: begin
            end
        endcase

        chip_address_port = busy ? addr_q : '0;
    end

endmodule

// File: tb/tb_prom_fuse_writer.sv
// Self-checking bench for prom_fuse_writer: directed vector table, reset/abort sequences,
// and randomized words checked against a per-bit pulse-count model of the fuse chip.
module tb_prom_fuse_writer;

    localparam int unsigned DW     = 8;
    localparam int unsigned AW     = 9;
    localparam int unsigned SC     = 2;
    localparam int unsigned PC     = 4;
    localparam int unsigned RC     = 2;
    localparam int unsigned RD     = 2;
    localparam int unsigned MR     = 3;
    localparam int          PHASE  = SC + PC + RC + RD;
    localparam int          BUDGET = 600;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic [DW-1:0] chip_data_in;
    logic [AW-1:0] chip_address_port;
    logic [DW-1:0] chip_data_out;
    logic          chip_data_oe;
    logic          chip_select_n;
    logic          program_enable;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] result_data;

    always #5 clk = ~clk;

    prom_fuse_writer #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .SETUP_CYCLES   (SC),
        .PULSE_CYCLES   (PC),
        .RECOVERY_CYCLES(RC),
        .READ_CYCLES    (RD),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .write_address    (write_address),
        .write_data       (write_data),
        .chip_data_in     (chip_data_in),
        .chip_address_port(chip_address_port),
        .chip_data_out    (chip_data_out),
        .chip_data_oe     (chip_data_oe),
        .chip_select_n    (chip_select_n),
        .program_enable   (program_enable),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .result_data      (result_data)
    );

    // Chip: a fuse blows once it has seen k complete pulses.
    logic [DW-1:0]      fuse;
    logic [DW-1:0][2:0] chip_k;
    int                 pulse_cnt [DW];
    assign chip_data_in = chip_select_n ? '0 : fuse;

    int            checks = 0;
    int            errors = 0;
    logic          pe_prev;
    int            width;
    logic [DW-1:0] cur_sel;
    int            n_pulses;
    logic [DW-1:0] pulse_mask;
    int            width_bad;
    int            inv_bad;
    int            done_cnt;
    logic [AW-1:0] exp_addr;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] pre;
        logic [DW-1:0] data;
        int            k_def;
        int            k3;
        logic          exp_err;
        logic [DW-1:0] exp_res;
        int            exp_np;
        logic [DW-1:0] exp_mask;
        int            exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Per-word reference: each needed bit costs min(k, MR) pulses; a bit needing more fails.
    function automatic void ref_model(input logic [DW-1:0] pre, input logic [DW-1:0] d,
                                      input logic [DW-1:0][2:0] kk, output logic err,
                                      output logic [DW-1:0] res, output int np,
                                      output logic [DW-1:0] msk, output int lat);
        logic [DW-1:0] f;
        int n;
        f   = pre;
        err = 1'b0;
        np  = 0;
        msk = '0;
        lat = 1 + RD + 1;
`ifdef PROM_FUSE_WRITER_BLANK_CHECK_EN
        if ((pre & ~d) != '0) begin
            err = 1'b1;
            res = pre;
            return;
        end
`endif
        for (int i = 0; i < DW; i++) begin
            lat += 1;
            if (d[i] && !f[i]) begin
                n = (int'(kk[i]) <= MR) ? int'(kk[i]) : MR;
                np += n;
                msk[i] = 1'b1;
                lat += n * PHASE;
                if (int'(kk[i]) <= MR) begin
                    f[i] = 1'b1;
                end else begin
                    err = 1'b1;
                    break;
                end
            end
        end
        res = f;
    endfunction

    // Observes one cycle at the falling edge and advances the chip model.
    task automatic monitor();
        if (program_enable) begin
            if (!chip_data_oe || !$onehot(chip_data_out)) inv_bad++;
            if (!pe_prev) begin
                width   = 1;
                cur_sel = chip_data_out;
            end else begin
                width++;
            end
        end else if (pe_prev) begin
            n_pulses++;
            pulse_mask |= cur_sel;
            if (width != PC) width_bad++;
            for (int i = 0; i < DW; i++) begin
                if (cur_sel[i]) begin
                    pulse_cnt[i]++;
                    if (pulse_cnt[i] >= int'(chip_k[i])) fuse[i] = 1'b1;
                end
            end
        end
        if (busy && chip_address_port !== exp_addr) inv_bad++;
        if (!busy && chip_address_port !== '0) inv_bad++;
        if (done) done_cnt++;
        pe_prev = program_enable;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic set_chip(input logic [DW-1:0] pre, input logic [DW-1:0][2:0] kk);
        fuse   = pre;
        chip_k = kk;
        for (int i = 0; i < DW; i++) pulse_cnt[i] = 0;
        n_pulses   = 0;
        pulse_mask = '0;
        width_bad  = 0;
        inv_bad    = 0;
        done_cnt   = 0;
    endtask

    // Call just after a falling edge; the next rising edge accepts start.
    task automatic do_txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] pre,
                          input logic [DW-1:0] d, input logic [DW-1:0][2:0] kk, input logic poke,
                          input logic e_err, input logic [DW-1:0] e_res, input int e_np,
                          input logic [DW-1:0] e_msk, input int e_lat);
        int            lat;
        logic          got_err;
        logic [DW-1:0] got_res;
        set_chip(pre, kk);
        exp_addr      = a;
        write_address = a;
        write_data    = d;
        start         = 1'b1;
        lat           = -1;
        got_err       = 1'bx;
        got_res       = 'x;
        @(posedge clk);
        #1;
        start         = 1'b0;
        write_address = AW'($urandom);
        write_data    = DW'($urandom);
        for (int c = 2; c < BUDGET; c++) begin
            tick();
            if (done) begin
                lat     = c;
                got_err = error;
                got_res = result_data;
                break;
            end
            if (poke) start = (c == 5);
        end
        start = 1'b0;
        chk({tag, ".timeout"}, (lat < 0) ? 1 : 0, 0);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".error"}, got_err, e_err);
        chk({tag, ".result"}, got_res, e_res);
        chk({tag, ".pulses"}, n_pulses, e_np);
        chk({tag, ".pulse_bits"}, pulse_mask, e_msk);
        chk({tag, ".pulse_width"}, width_bad, 0);
        chk({tag, ".invariants"}, inv_bad, 0);
        tick();
        chk({tag, ".done_one_cycle"}, {done, busy}, 2'b00);
        chk({tag, ".result_held"}, result_data, e_res);
    endtask

    function automatic logic [DW-1:0][2:0] k_word(input int k_def, input int k3);
        logic [DW-1:0][2:0] kk;
        for (int i = 0; i < DW; i++) kk[i] = 3'(k_def);
        kk[3] = 3'(k3);
        return kk;
    endfunction

    initial begin
        logic [DW-1:0][2:0] kk;
        logic               e_err;
        logic [DW-1:0]      e_res;
        logic [DW-1:0]      e_msk;
        logic [DW-1:0]      pre;
        logic [DW-1:0]      d;
        int                 e_np;
        int                 e_lat;
        int                 guard;

        vecs[0] = '{9'h1A5, 8'h00, 8'hA5, 1, 1, 1'b0, 8'hA5, 4, 8'hA5, 52};
        vecs[1] = '{9'h033, 8'h00, 8'h00, 1, 1, 1'b0, 8'h00, 0, 8'h00, 12};
        vecs[2] = '{9'h008, 8'h00, 8'h08, 1, 3, 1'b0, 8'h08, 3, 8'h08, 42};
        vecs[3] = '{9'h008, 8'h00, 8'h08, 1, 4, 1'b1, 8'h00, 3, 8'h08, 38};
`ifdef PROM_FUSE_WRITER_BLANK_CHECK_EN
        vecs[4] = '{9'h0FF, 8'h01, 8'h02, 1, 1, 1'b1, 8'h01, 0, 8'h00, 4};
`else
        vecs[4] = '{9'h0FF, 8'h01, 8'h02, 1, 1, 1'b0, 8'h03, 1, 8'h02, 22};
`endif
        vecs[5] = '{9'h100, 8'h5A, 8'h5A, 1, 1, 1'b0, 8'h5A, 0, 8'h00, 12};
        vecs[6] = '{9'h0C3, 8'h00, 8'h81, 2, 2, 1'b0, 8'h81, 4, 8'h81, 52};
        vecs[7] = '{9'h1FF, 8'h00, 8'h01, 4, 4, 1'b1, 8'h00, 3, 8'h01, 35};

        reset         = 1'b1;
        start         = 1'b0;
        write_address = '0;
        write_data    = '0;
        pe_prev       = 1'b0;
        width         = 0;
        cur_sel       = '0;
        exp_addr      = '0;
        set_chip('0, k_word(1, 1));

        #12;
        chk("reset.busy", busy, 0);
        chk("reset.done_error", {done, error}, 2'b00);
        chk("reset.cs_n", chip_select_n, 1);
        chk("reset.pe_oe", {program_enable, chip_data_oe}, 2'b00);
        chk("reset.data_out", chip_data_out, 0);
        chk("reset.address", chip_address_port, 0);
        chk("reset.result", result_data, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].pre, vecs[i].data,
                   k_word(vecs[i].k_def, vecs[i].k3), 1'b0, vecs[i].exp_err, vecs[i].exp_res,
                   vecs[i].exp_np, vecs[i].exp_mask, vecs[i].exp_lat);
        end

        // Start pulsed mid-operation must not disturb the latched request.
        do_txn("poke", 9'h1A5, 8'h00, 8'hA5, k_word(1, 1), 1'b1, 1'b0, 8'hA5, 4, 8'hA5, 52);

        // Abort during the second pulse cycle.
        set_chip('0, k_word(4, 4));
        exp_addr      = 9'h055;
        write_address = 9'h055;
        write_data    = 8'h01;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!program_enable && guard < 50) begin
            tick();
            guard++;
        end
        chk("abort.reached_pulse", program_enable, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort.pe_async", program_enable, 0);
        chk("abort.busy_async", busy, 0);
        chk("abort.address", chip_address_port, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        chk("abort.no_done", done_cnt, 0);
        chk("abort.idle", busy, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // Start offered in the very cycle after reset releases.
        do_txn("after_reset", 9'h0AA, 8'h00, 8'h10, k_word(1, 1), 1'b0, 1'b0, 8'h10, 1,
               8'h10, 22);

        for (int t = 0; t < 24; t++) begin
            pre = DW'($urandom) & DW'($urandom);
            d   = DW'($urandom);
            if (t % 3 == 0) pre = pre & d;
            for (int i = 0; i < DW; i++) kk[i] = 3'($urandom_range(1, 4));
            ref_model(pre, d, kk, e_err, e_res, e_np, e_msk, e_lat);
            do_txn($sformatf("rand%0d", t), AW'($urandom), pre, d, kk, (t % 4 == 1), e_err,
                   e_res, e_np, e_msk, e_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
